// File: rtl/glitcbus_pkg.sv
// -----------------------------------------------------------------------------
// glitcbus_pkg
// Shared definitions for the GLITCBUS protocol: the transaction state
// encoding and the status bytes returned on GAD at the end of every
// transaction. Kept in one place so a GLITCBUS master can reuse them.
// -----------------------------------------------------------------------------
package glitcbus_pkg;

  // Transaction phases, in the order they occur on the wire.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,  // waiting for a select falling edge
    ST_ADR1 = 3'd1,  // high address byte on GAD
    ST_WDAT = 3'd2,  // four write-data bytes, LSB first
    ST_WB   = 3'd3,  // WISHBONE cycle in flight
    ST_STAT = 3'd4,  // one status byte driven on GAD
    ST_RDAT = 3'd5,  // four read-data bytes driven, LSB first
    ST_DONE = 3'd6   // transaction over, waiting for select release
  } gb_state_e;

  // Status bytes seen by the GLITCBUS master.
  localparam logic [7:0] STATUS_OK   = 8'hA5;  // WISHBONE ack
  localparam logic [7:0] STATUS_ERR  = 8'hEE;  // WISHBONE err or rty
  localparam logic [7:0] STATUS_TMO  = 8'hE7;  // no termination in time
  localparam logic [7:0] STATUS_WAIT = 8'h00;  // still busy

  // Byte idx (0 = LSB) of a 32-bit word.
  function automatic logic [7:0] get_byte(input logic [31:0] word,
                                          input logic [1:0]  idx);
    return word[{idx, 3'b000} +: 8];
  endfunction

endpackage : glitcbus_pkg

// File: rtl/glitcbus_slave.sv
// -----------------------------------------------------------------------------
// glitcbus_slave
// Bridges the byte-wide GLITCBUS onto a 32-bit WISHBONE master port.
// A transaction is framed by gsel_b_i low: low address byte, high address
// byte, four write-data bytes (writes only), then one WISHBONE cycle. The
// slave then drives one status byte and, for a successful read, four
// read-data bytes back on GAD.
//
// Ports
//   clk_i, rst_i        single clock, synchronous active-high reset
//   gsel_b_i            active-low transaction select
//   grdwr_b_i           1 = read, 0 = write (taken on the first select cycle)
//   gad_i/gad_o/gad_oe_o split bidirectional GAD byte bus
//   cyc_o stb_o we_o adr_o dat_o sel_o   WISHBONE master request
//   dat_i ack_i err_i rty_i              WISHBONE master response
// -----------------------------------------------------------------------------
module glitcbus_slave #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        gsel_b_i,
  input  logic        grdwr_b_i,
  input  logic [7:0]  gad_i,
  output logic [7:0]  gad_o,
  output logic        gad_oe_o,
  output logic        cyc_o,
  output logic        stb_o,
  output logic        we_o,
  output logic [15:0] adr_o,
  output logic [31:0] dat_o,
  output logic [3:0]  sel_o,
  input  logic [31:0] dat_i,
  input  logic        ack_i,
  input  logic        err_i,
  input  logic        rty_i
);

  import glitcbus_pkg::*;

  // The counter holds the index of the current WB cycle, so it must reach
  // TIMEOUT_CYCLES-1.
  localparam int              CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  gb_state_e        state_q,  state_d;
  logic             rd_q,     rd_d;
  logic [15:0]      adr_q,    adr_d;
  logic [31:0]      dat_q,    dat_d;     // write data, then read data
  logic [1:0]       beat_q,   beat_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [7:0]       status_q, status_d;
  logic             gsel_b_q, gsel_b_d;  // previous select, for edge detect

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop, independent of order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      rd_q     <= 1'b0;
      adr_q    <= '0;
      dat_q    <= '0;
      beat_q   <= '0;
      cnt_q    <= '0;
      status_q <= STATUS_WAIT;
      // Treated as "select was low" so a select held low through reset
      // release cannot start a transaction without a fresh falling edge.
      gsel_b_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_q     <= rd_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      beat_q   <= beat_d;
      cnt_q    <= cnt_d;
      status_q <= status_d;
      gsel_b_q <= gsel_b_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets its hold value first; a path that forgets to
    // assign one would otherwise infer a latch.
    state_d  = state_q;
    rd_d     = rd_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    beat_d   = beat_q;
    cnt_d    = cnt_q;
    status_d = status_q;
    gsel_b_d = gsel_b_i;

    if (state_q == ST_IDLE) begin
      if (!gsel_b_i && gsel_b_q) begin
        rd_d     = grdwr_b_i;
        adr_d    = {8'h00, gad_i};
        dat_d    = '0;
        beat_d   = '0;
        cnt_d    = '0;
        status_d = STATUS_WAIT;
        state_d  = ST_ADR1;
      end
    end else if (gsel_b_i) begin
      // Select released: a normal exit from DONE, an abort anywhere else.
      // A WISHBONE response arriving later is ignored because IDLE never
      // looks at the response inputs.
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_ADR1: begin
          adr_d[15:8] = gad_i;
          beat_d      = '0;
          cnt_d       = '0;
          state_d     = rd_q ? ST_WB : ST_WDAT;
        end

        ST_WDAT: begin
          dat_d[{beat_q, 3'b000} +: 8] = gad_i;
          beat_d = beat_q + 2'd1;
          if (beat_q == 2'd3) begin
            cnt_d   = '0;
            state_d = ST_WB;
          end
        end

        ST_WB: begin
          // ack wins over err/rty; a termination on the final allowed
          // cycle still beats the timeout.
          if (ack_i) begin
            status_d = STATUS_OK;
            if (rd_q) dat_d = dat_i;
            state_d = ST_STAT;
          end else if (err_i || rty_i) begin
            status_d = STATUS_ERR;
            state_d  = ST_STAT;
          end else if (cnt_q == CNT_LAST) begin
            status_d = STATUS_TMO;
            state_d  = ST_STAT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        ST_STAT: begin
          beat_d  = '0;
          state_d = (rd_q && status_q == STATUS_OK) ? ST_RDAT : ST_DONE;
        end

        ST_RDAT: begin
          beat_d = beat_q + 2'd1;
          if (beat_q == 2'd3) state_d = ST_DONE;
        end

        default: ;  // ST_DONE waits for select release, handled above
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs, decoded from registered state only
  // ---------------------------------------------------------------------------
  always_comb begin
    gad_o    = 8'h00;
    gad_oe_o = 1'b0;
    cyc_o    = 1'b0;
    stb_o    = 1'b0;
    we_o     = 1'b0;
    adr_o    = '0;
    dat_o    = '0;
    sel_o    = '0;

    unique case (state_q)
      ST_WB: begin
        cyc_o = 1'b1;
        stb_o = 1'b1;
        we_o  = !rd_q;
        sel_o = 4'hF;
        adr_o = adr_q;
        dat_o = dat_q;
        // The first WB cycle is the GAD turnaround: the master has just
        // stopped driving, so the slave stays off the bus for one cycle.
        if (cnt_q != '0) begin
          gad_oe_o = 1'b1;
          gad_o    = STATUS_WAIT;
        end
      end

      ST_STAT: begin
        gad_oe_o = 1'b1;
        gad_o    = status_q;
      end

      ST_RDAT: begin
        gad_oe_o = 1'b1;
        gad_o    = get_byte(dat_q, beat_q);
      end

      default: ;
    endcase
  end

endmodule : glitcbus_slave

// File: tb/tb_glitcbus_slave.sv
// -----------------------------------------------------------------------------
// tb_glitcbus_slave
// Drives GLITCBUS transactions into glitcbus_slave, plays the WISHBONE slave
// itself and checks both buses against a transaction-level model: a sparse
// memory of 32-bit words plus the protocol's byte sequence for each outcome.
// -----------------------------------------------------------------------------
module tb_glitcbus_slave;

  localparam int TMO = 255;

  localparam int T_ACK  = 0;
  localparam int T_ERR  = 1;
  localparam int T_RTY  = 2;
  localparam int T_NONE = 3;
  localparam int T_BOTH = 4;  // ack and err in the same cycle

  logic        clk;
  logic        rst_i;
  logic        gsel_b_i;
  logic        grdwr_b_i;
  logic [7:0]  gad_i;
  logic [7:0]  gad_o;
  logic        gad_oe_o;
  logic        cyc_o;
  logic        stb_o;
  logic        we_o;
  logic [15:0] adr_o;
  logic [31:0] dat_o;
  logic [3:0]  sel_o;
  logic [31:0] dat_i;
  logic        ack_i;
  logic        err_i;
  logic        rty_i;

  int n_cmp = 0;
  int n_err = 0;

  // Reference memory behind the WISHBONE port.
  logic [31:0] mem [logic [15:0]];

  glitcbus_slave #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .gsel_b_i  (gsel_b_i),
    .grdwr_b_i (grdwr_b_i),
    .gad_i     (gad_i),
    .gad_o     (gad_o),
    .gad_oe_o  (gad_oe_o),
    .cyc_o     (cyc_o),
    .stb_o     (stb_o),
    .we_o      (we_o),
    .adr_o     (adr_o),
    .dat_o     (dat_o),
    .sel_o     (sel_o),
    .dat_i     (dat_i),
    .ack_i     (ack_i),
    .err_i     (err_i),
    .rty_i     (rty_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cyc"},   cyc_o,    1'b0);
    check({tag, "_stb"},   stb_o,    1'b0);
    check({tag, "_we"},    we_o,     1'b0);
    check({tag, "_oe"},    gad_oe_o, 1'b0);
    check({tag, "_gad"},   gad_o,    8'h00);
    check({tag, "_adr"},   adr_o,    16'h0000);
    check({tag, "_dat"},   dat_o,    32'h0);
    check({tag, "_sel"},   sel_o,    4'h0);
  endtask

  // One complete GLITCBUS transaction. Outputs are sampled at the falling
  // edge (state after the previous rising edge), then the inputs for the
  // current cycle are applied. abort_k >= 0 releases select in WB cycle
  // abort_k; rst_beat >= 0 pulses reset during that write-data beat.
  task automatic run_txn(input bit rd, input logic [15:0] adr, input logic [31:0] wdata,
                         input int term, input int delay, input int abort_k,
                         input int rst_beat);
    logic [31:0] rdata;
    logic [7:0]  exp_st;
    int          n_wb;

    rdata = 32'h0;
    if (rd) begin
      if (!mem.exists(adr)) mem[adr] = $urandom;
      rdata = mem[adr];
    end
    case (term)
      T_ACK, T_BOTH: exp_st = 8'hA5;
      T_ERR, T_RTY:  exp_st = 8'hEE;
      default:       exp_st = 8'hE7;
    endcase
    n_wb = (term == T_NONE) ? TMO : delay + 1;

    // Select falling edge with the low address byte.
    @(negedge clk);
    check("idle_oe",  gad_oe_o, 1'b0);
    check("idle_cyc", cyc_o,    1'b0);
    gsel_b_i  = 1'b0;
    grdwr_b_i = rd;
    gad_i     = adr[7:0];

    // High address byte; direction flipped to show it is not resampled.
    @(negedge clk);
    check("adr1_oe",  gad_oe_o, 1'b0);
    check("adr1_cyc", cyc_o,    1'b0);
    gad_i     = adr[15:8];
    grdwr_b_i = ~rd;

    if (!rd) begin
      for (int b = 0; b < 4; b++) begin
        @(negedge clk);
        check("wdat_oe",  gad_oe_o, 1'b0);
        check("wdat_cyc", cyc_o,    1'b0);
        gad_i = wdata[8*b +: 8];
        if (b == rst_beat) begin
          rst_i = 1'b1;
          @(negedge clk);
          check_reset_outputs("midrst");
          rst_i     = 1'b0;
          grdwr_b_i = 1'b1;
          // Select still low since before reset: no edge, so no start.
          for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("nostart_cyc", cyc_o,    1'b0);
            check("nostart_oe",  gad_oe_o, 1'b0);
          end
          gsel_b_i = 1'b1;
          return;
        end
      end
    end

    for (int k = 0; k < n_wb; k++) begin
      @(negedge clk);
      check("wb_cyc", cyc_o,    1'b1);
      check("wb_stb", stb_o,    1'b1);
      check("wb_oe",  gad_oe_o, (k != 0));
      if (k != 0) check("wb_wait", gad_o, 8'h00);
      if (k == 0 || k == n_wb - 1) begin
        check("wb_we",  we_o,  !rd);
        check("wb_adr", adr_o, adr);
        check("wb_sel", sel_o, 4'hF);
        if (!rd) check("wb_dat", dat_o, wdata);
      end
      ack_i = 1'b0;
      err_i = 1'b0;
      rty_i = 1'b0;
      dat_i = $urandom;
      if (k == abort_k) begin
        gsel_b_i = 1'b1;
        @(negedge clk);
        check("abort_cyc", cyc_o,    1'b0);
        check("abort_stb", stb_o,    1'b0);
        check("abort_oe",  gad_oe_o, 1'b0);
        ack_i = 1'b1;  // late response
        dat_i = $urandom;
        @(negedge clk);
        check("late_ack_cyc", cyc_o,    1'b0);
        check("late_ack_oe",  gad_oe_o, 1'b0);
        ack_i = 1'b0;
        return;
      end
      if (k == delay && term != T_NONE) begin
        case (term)
          T_ACK:   ack_i = 1'b1;
          T_ERR:   err_i = 1'b1;
          T_RTY:   rty_i = 1'b1;
          default: begin ack_i = 1'b1; err_i = 1'b1; end
        endcase
        if (rd) dat_i = rdata;
      end
    end

    // Status byte.
    @(negedge clk);
    ack_i = 1'b0;
    err_i = 1'b0;
    rty_i = 1'b0;
    dat_i = $urandom;
    check("stat_cyc", cyc_o,    1'b0);
    check("stat_oe",  gad_oe_o, 1'b1);
    check("stat_code", gad_o,   exp_st);
    if (!rd && exp_st == 8'hA5) mem[adr] = wdata;

    if (rd && exp_st == 8'hA5) begin
      for (int b = 0; b < 4; b++) begin
        @(negedge clk);
        check("rdat_oe",   gad_oe_o, 1'b1);
        check("rdat_byte", gad_o,    rdata[8*b +: 8]);
      end
    end

    // DONE, then release select.
    @(negedge clk);
    check("done_oe",  gad_oe_o, 1'b0);
    check("done_cyc", cyc_o,    1'b0);
    gsel_b_i = 1'b1;
    gad_i    = 8'($urandom);
  endtask

  initial begin
    rst_i     = 1'b1;
    gsel_b_i  = 1'b1;
    grdwr_b_i = 1'b1;
    gad_i     = 8'h00;
    dat_i     = 32'h0;
    ack_i     = 1'b0;
    err_i     = 1'b0;
    rty_i     = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_i = 1'b0;
    @(negedge clk);

    // Write with a 3-cycle WB wait: GAD shows turnaround, 00, 00, A5.
    run_txn(1'b0, 16'h1234, 32'hDEADBEEF, T_ACK, 2, -1, -1);
    // Read acked in the first WB cycle.
    mem[16'h0010] = 32'h01020304;
    run_txn(1'b1, 16'h0010, 32'h0, T_ACK, 0, -1, -1);
    // Read back the earlier write.
    run_txn(1'b1, 16'h1234, 32'h0, T_ACK, 1, -1, -1);
    // Timeout, error, retry, simultaneous ack+err.
    run_txn(1'b1, 16'h0777, 32'h0, T_NONE, 0, -1, -1);
    run_txn(1'b0, 16'h0020, 32'h11223344, T_ERR, 1, -1, -1);
    run_txn(1'b1, 16'h0010, 32'h0, T_RTY, 0, -1, -1);
    run_txn(1'b1, 16'h0010, 32'h0, T_BOTH, 3, -1, -1);
    // Abort in WB cycle 2, then a normal transaction.
    run_txn(1'b0, 16'h1234, 32'hCAFEF00D, T_ACK, 3, 1, -1);
    run_txn(1'b1, 16'h1234, 32'h0, T_ACK, 0, -1, -1);
    // Reset during write beat 2 discards the write.
    run_txn(1'b0, 16'h0010, 32'hFFFFFFFF, T_ACK, 0, -1, 2);
    run_txn(1'b1, 16'h0010, 32'h0, T_ACK, 0, -1, -1);

    // Randomised traffic over a small address window.
    for (int n = 0; n < 40; n++) begin
      bit          rd;
      logic [15:0] adr;
      int          r;
      int          term;
      rd  = 1'($urandom_range(0, 1));
      adr = 16'h0100 + 16'($urandom_range(0, 5));
      r   = $urandom_range(0, 9);
      term = (r < 7) ? T_ACK : (r == 7) ? T_ERR : (r == 8) ? T_RTY : T_BOTH;
      run_txn(rd, adr, $urandom, term, $urandom_range(0, 4), -1, -1);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        check("gap_oe",  gad_oe_o, 1'b0);
        check("gap_cyc", cyc_o,    1'b0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_glitcbus_slave

// File: doc/glitcbus_slave.md
GLITCBUS_SLAVE -- requirements
Module: glitcbus_slave

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: WISHBONE cycles waited for ack/err/rty before a timeout status.
REQ-002 SHALL have port clk_i, input, 1: single clock; all GLITCBUS inputs are synchronous to it.
REQ-003 SHALL have port rst_i, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port gsel_b_i, input, 1: active-low select; low frames one transaction.
REQ-005 SHALL have port grdwr_b_i, input, 1: 1=read, 0=write; sampled on the first select-low cycle only.
REQ-006 SHALL have ports gad_i, input, 8 / gad_o, output, 8 / gad_oe_o, output, 1: split GAD bidirectional byte bus.
REQ-007 SHALL have WISHBONE master ports cyc_o, stb_o, we_o (1 each), adr_o (16), dat_o (32), sel_o (4), dat_i (32), ack_i, err_i, rty_i (1 each).

Function
REQ-008 SHALL implement states IDLE, ADR1, WDAT, WB, STAT, RDAT, DONE.
REQ-009 IDLE: on gsel_b_i=0, SHALL latch rd=grdwr_b_i and adr[7:0]=gad_i in the same cycle, then go to ADR1.
REQ-010 ADR1: SHALL latch adr[15:8]=gad_i; write -> WDAT with beat=0; read -> WB.
REQ-011 WDAT: SHALL latch dat[8*beat+:8]=gad_i each cycle, beat 0..3 LSB first; after beat 3 -> WB.
REQ-012 WB: SHALL drive cyc_o=stb_o=1, we_o=!rd, sel_o=4'hF, adr_o=adr, dat_o=dat until termination.
REQ-013 WB: gad_oe_o SHALL be 0 in the first WB cycle (turnaround), then 1 with gad_o=8'h00 (wait) every later WB cycle.
REQ-014 WB termination: ack_i -> status 8'hA5, latch dat_i if read; err_i or rty_i -> 8'hEE; ack_i has priority if asserted together.
REQ-015 WB: if no termination after TIMEOUT_CYCLES cycles, SHALL end with status 8'hE7; cyc_o/stb_o SHALL deassert in the cycle after termination or timeout.
REQ-016 STAT: SHALL drive gad_oe_o=1 and gad_o=status for exactly one cycle.
REQ-016a STAT exit: read with status A5 -> RDAT; otherwise -> DONE.
REQ-017 RDAT: SHALL drive read data bytes 0..3 LSB first, one per cycle, gad_oe_o=1, then -> DONE.
REQ-018 DONE: gad_oe_o=0; SHALL wait for gsel_b_i=1, then -> IDLE.
REQ-019 Abort: gsel_b_i=1 in any state other than IDLE/DONE SHALL return to IDLE next cycle.
REQ-019a Abort effects: cyc_o, stb_o and gad_oe_o deasserted; a late ack_i is ignored.
REQ-020 gad_oe_o SHALL never be 1 in IDLE, ADR1, WDAT, DONE, or the first WB cycle.
REQ-021 Back-to-back: select reasserted in the cycle after DONE->IDLE SHALL start a new transaction normally.
REQ-022 Minimum latency: write select-low to A5 status = 8 cycles; read select-low to A5 status = 4 cycles, with ack in the first WB cycle.

Reset
REQ-023 rst_i=1 SHALL force IDLE; beat=0; timeout counter=0.
REQ-023a rst_i=1 SHALL force cyc_o=stb_o=we_o=0, gad_oe_o=0, gad_o=0, adr_o=0, dat_o=0, sel_o=0.
REQ-024 Reset mid-transaction SHALL drop cyc_o next cycle and discard all latched data.
REQ-024a After reset release, the first transaction SHALL begin only on a fresh gsel_b_i falling edge seen from IDLE.

Structure
REQ-025 Shared package glitcbus_pkg SHALL hold status constants (A5 OK, EE ERR, E7 TMO, 00 WAIT) and the state encoding, for reuse by glitcbus_master_v2.
REQ-026 No sub-module; timeout counter and byte shifters are inline.

Verification
REQ-027 Write: adr 0x1234, data 0xDEADBEEF over beats 34,12,EF,BE,AD,DE; ack after 3 cycles -> WB write adr_o=0x1234, dat_o=0xDEADBEEF, then GAD 00,00,A5.
REQ-028 Read: adr 0x0010; ack in the first WB cycle with dat_i=0x01020304 -> GAD oe=0 one cycle, then A5,04,03,02,01.
REQ-029 Timeout: read with no ack -> cyc_o held TIMEOUT_CYCLES (255) cycles, status E7, no data beats.
REQ-029a Error: err_i=1 -> status EE, cyc_o drops next cycle.
REQ-030 Abort: gsel_b_i high during WB cycle 2 -> cyc_o=0 and gad_oe_o=0 next cycle; ack_i one cycle later ignored; next transaction correct.
REQ-031 Reset: rst_i pulsed during WDAT beat 2 -> all outputs at reset values next cycle; a following read returns correct data.
